// File: rtl/nand_lab_pkg.sv
// Shared definitions for the gate-equivalence sequencer.
//   state_t        : sequencer FSM states
//   minterm_count  : number of minterms swept for a given input count
//   cmp_result_t   : one COMPARE-cycle outcome {mism, idx}
package nand_lab_pkg;

  localparam int MAX_N_IN   = 8;
  localparam int MAX_SETTLE = 15;
  localparam int CNT_W      = 4;   // wide enough for MAX_SETTLE-1

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic                mism;  // f_ref and f_dut disagreed this cycle
    logic [MAX_N_IN-1:0] idx;   // minterm under comparison
  } cmp_result_t;

  function automatic int minterm_count(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/nand_equiv_sequencer_if.sv
// Handshake/result bundle between the sequencer and the lab bench.
//   start                    : request a sweep
//   vec                      : minterm index fed to both function units
//   f_ref, f_dut             : function unit outputs
//   busy, done, pass         : sweep status
//   mism_count, first_mism,
//   first_valid              : sweep results
// master = bench side, slave = sequencer side.
interface nand_equiv_sequencer_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic [N_IN-1:0] vec;
  logic            f_ref;
  logic            f_dut;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   mism_count;
  logic [N_IN-1:0] first_mism;
  logic            first_valid;

  modport master (
    output start, f_ref, f_dut,
    input  vec, busy, done, pass, mism_count, first_mism, first_valid
  );

  modport slave (
    input  start, f_ref, f_dut,
    output vec, busy, done, pass, mism_count, first_mism, first_valid
  );
endinterface

// File: rtl/nand_equiv_sequencer_minterm_counter.sv
// Loadable minterm index counter.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : reset the index to 0 (start of sweep)
//   inc        : advance to the next minterm
//   idx        : current minterm index
//   last       : idx is the final minterm (all ones)
// The increment is ignored at the last minterm so the index never wraps
// inside a sweep; only clr brings it back to 0.
module minterm_counter #(
  parameter int N_IN = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inc,
  output logic [N_IN-1:0] idx,
  output logic            last
);

  assign last = &idx;

  always_ff @(posedge clk) begin
    if (!rst_n)
      idx <= '0;
    else if (clr)
      idx <= '0;
    else if (inc && !last)
      idx <= idx + 1'b1;
  end

endmodule

// File: rtl/nand_equiv_sequencer.sv
// Sweeps every minterm through a reference and a gate-only function unit
// and compares their outputs one minterm at a time.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : start/vec/f_ref/f_dut handshake and result outputs
// Each minterm is held SETTLE cycles (SETTLE state) and then sampled for
// one cycle (COMPARE). done pulses for one cycle after the last minterm.
module nand_equiv_sequencer
  import nand_lab_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nand_equiv_sequencer_if.slave  bus
);

  localparam int MW = N_IN + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  state_t            state, nxt;
  logic [CNT_W-1:0]  cnt;
  logic [N_IN-1:0]   vec;
  logic              last;
  logic [MW-1:0]     mism_count;
  logic [MW-1:0]     mism_nxt;
  logic [N_IN-1:0]   first_mism;
  logic              first_valid;
  logic              pass;
  cmp_result_t       cmp;
  logic              unused_idx;

  // FSM control strobes
  logic clr_res, vec_clr, vec_inc, cnt_ld, cnt_dec, do_cmp;

  minterm_counter #(.N_IN(N_IN)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (vec_clr),
    .inc   (vec_inc),
    .idx   (vec),
    .last  (last)
  );

  // Unit outputs only matter while comparing, so X elsewhere is masked.
  assign cmp.mism = do_cmp && (bus.f_ref != bus.f_dut);
  assign cmp.idx  = MAX_N_IN'(vec);
  assign unused_idx = ^cmp.idx;

  assign mism_nxt = mism_count + MW'(cmp.mism);

  always_comb begin
    nxt     = state;
    clr_res = 1'b0;
    vec_clr = 1'b0;
    vec_inc = 1'b0;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    do_cmp  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          clr_res = 1'b1;
          vec_clr = 1'b1;
          cnt_ld  = 1'b1;
          nxt     = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt == '0) nxt = S_COMPARE;
        else           cnt_dec = 1'b1;
      end
      S_COMPARE: begin
        do_cmp = 1'b1;
        if (last) begin
          nxt = S_DONE;
        end else begin
          vec_inc = 1'b1;
          cnt_ld  = 1'b1;
          nxt     = S_SETTLE;
        end
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mism_count  <= '0;
      first_mism  <= '0;
      first_valid <= 1'b0;
      pass        <= 1'b0;
    end else begin
      state <= nxt;

      if (cnt_ld)       cnt <= CNT_LOAD;
      else if (cnt_dec) cnt <= cnt - 1'b1;

      if (clr_res) begin
        mism_count  <= '0;
        first_mism  <= '0;
        first_valid <= 1'b0;
        pass        <= 1'b0;
      end else if (cmp.mism) begin
        mism_count <= mism_nxt;
        // Minterms are visited in ascending order, so the first capture
        // is the lowest failing index.
        if (!first_valid) begin
          first_mism  <= cmp.idx[N_IN-1:0];
          first_valid <= 1'b1;
        end
      end

      // Registered on the way into DONE so the last compare is included.
      if (do_cmp && last) pass <= (mism_nxt == '0);
    end
  end

  assign bus.vec         = vec;
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE);
  assign bus.pass        = pass;
  assign bus.mism_count  = mism_count;
  assign bus.first_mism  = first_mism;
  assign bus.first_valid = first_valid;

endmodule

// File: tb/tb_nand_equiv_sequencer.sv
// Bench for nand_equiv_sequencer: two instances (SETTLE=1 and SETTLE=3,
// N_IN=2) driven by truth-table function units. Expected results come from
// table arithmetic: popcount of ref^dut, lowest differing bit, and the
// sweep latency 2^N*(SETTLE+1)+1.
module tb_nand_equiv_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Truth tables indexed by minterm (bit i = f at minterm i, x is MSB).
  logic [3:0] ref_tbl = 4'b0111;          // ~x | ~y
  logic [3:0] dut_tbl [2];
  logic       start_r [2];

  nand_equiv_sequencer_if #(.N_IN(2)) if0 ();
  nand_equiv_sequencer_if #(.N_IN(2)) if1 ();

  assign if0.start = start_r[0];
  assign if1.start = start_r[1];
  assign if0.f_ref = ref_tbl[if0.vec];
  assign if1.f_ref = ref_tbl[if1.vec];
  assign if0.f_dut = dut_tbl[0][if0.vec];
  assign if1.f_dut = dut_tbl[1][if1.vec];

  nand_equiv_sequencer #(.N_IN(2), .SETTLE(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  nand_equiv_sequencer #(.N_IN(2), .SETTLE(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic [1:0] vec_o   [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic       pass_o  [2];
  logic [2:0] mism_o  [2];
  logic [1:0] first_o [2];
  logic       fv_o    [2];

  assign vec_o[0] = if0.vec;          assign vec_o[1] = if1.vec;
  assign busy_o[0] = if0.busy;        assign busy_o[1] = if1.busy;
  assign done_o[0] = if0.done;        assign done_o[1] = if1.done;
  assign pass_o[0] = if0.pass;        assign pass_o[1] = if1.pass;
  assign mism_o[0] = if0.mism_count;  assign mism_o[1] = if1.mism_count;
  assign first_o[0] = if0.first_mism; assign first_o[1] = if1.first_mism;
  assign fv_o[0] = if0.first_valid;   assign fv_o[1] = if1.first_valid;

  int checks = 0;
  int errors = 0;
  int nsw    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_results(input int w, input string tag, input logic p, input int m,
                             input int f, input logic fv);
    chk($sformatf("%s.pass", tag),  32'(pass_o[w]),  32'(p));
    chk($sformatf("%s.mism", tag),  32'(mism_o[w]),  32'(m));
    chk($sformatf("%s.first", tag), 32'(first_o[w]), 32'(f));
    chk($sformatf("%s.fv", tag),    32'(fv_o[w]),    32'(fv));
  endtask

  // Entered at a negedge with instance idle; start is accepted on the next
  // posedge. Cycle c is observed at the c-th negedge after acceptance.
  task automatic sweep(input int w, input logic [3:0] tbl, input bit hold);
    int s, len, exp_m, exp_f;
    logic [3:0] diff;
    string tag;
    s   = (w == 0) ? 1 : 3;
    len = 4 * (s + 1) + 1;
    diff  = ref_tbl ^ tbl;
    exp_m = $countones(diff);
    exp_f = 0;
    for (int i = 3; i >= 0; i--) if (diff[i]) exp_f = i;
    nsw++;
    tag = $sformatf("sw%0d.u%0d.t%h", nsw, w, tbl);
    dut_tbl[w] = tbl;
    start_r[w] = 1'b1;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) start_r[w] = 1'b0;
      if (c < len) begin
        chk($sformatf("%s.c%0d.done", tag, c), 32'(done_o[w]), 32'd0);
        chk($sformatf("%s.c%0d.busy", tag, c), 32'(busy_o[w]), 32'd1);
        chk($sformatf("%s.c%0d.vec", tag, c),  32'(vec_o[w]),  32'((c - 1) / (s + 1)));
      end else begin
        chk($sformatf("%s.done", tag), 32'(done_o[w]), 32'd1);
        chk($sformatf("%s.vec_hold", tag), 32'(vec_o[w]), 32'd3);
        chk_results(w, tag, exp_m == 0, exp_m, exp_f, exp_m != 0);
      end
    end
    // One IDLE cycle; results must hold, done must have dropped.
    @(negedge clk);
    chk($sformatf("%s.idle.busy", tag), 32'(busy_o[w]), 32'd0);
    chk($sformatf("%s.idle.done", tag), 32'(done_o[w]), 32'd0);
    chk_results(w, {tag, ".idle"}, exp_m == 0, exp_m, exp_f, exp_m != 0);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("%s.u%0d.vec", tag, w),  32'(vec_o[w]),  32'd0);
      chk($sformatf("%s.u%0d.busy", tag, w), 32'(busy_o[w]), 32'd0);
      chk($sformatf("%s.u%0d.done", tag, w), 32'(done_o[w]), 32'd0);
      chk_results(w, $sformatf("%s.u%0d", tag, w), 1'b0, 0, 0, 1'b0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    dut_tbl[0] = 4'b0111;
    dut_tbl[1] = 4'b0111;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed sweeps: NAND (match), x|y (minterms 0,3), ~y (minterm 1).
    sweep(0, 4'b0111, 1'b0);
    sweep(0, 4'b1110, 1'b0);
    sweep(0, 4'b0101, 1'b0);
    sweep(1, 4'b0111, 1'b0);
    sweep(1, 4'b1110, 1'b0);

    // Abort: extra start mid-run is ignored, reset kills the sweep.
    dut_tbl[0] = 4'b1000;
    start_r[0] = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) start_r[0] = 1'b0;
      if (c == 4) start_r[0] = 1'b1;
      if (c == 5) begin
        start_r[0] = 1'b0;
        chk("abort.c5.vec", 32'(vec_o[0]), 32'd2);
        chk("abort.c5.busy", 32'(busy_o[0]), 32'd1);
      end
      if (c == 6) rst_n = 1'b0;
      if (c == 7) begin
        chk_all_zero("abort.rst");
        rst_n = 1'b1;
      end
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("abort.quiet%0d.done", c), 32'(done_o[0]), 32'd0);
      chk($sformatf("abort.quiet%0d.busy", c), 32'(busy_o[0]), 32'd0);
    end
    sweep(0, 4'b0111, 1'b0);

    // start held high: back-to-back sweeps every 10 cycles.
    for (int k = 0; k < 3; k++) sweep(0, 4'($urandom), 1'b1);
    sweep(0, 4'($urandom), 1'b0);

    // Random tables on both instances.
    for (int k = 0; k < 8; k++) sweep(k % 2, 4'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
